// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// segment width, logical segment type and the hex-to-segment encoding table.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    // Logical (active-high) segment pattern, bit 6 = a ... bit 0 = g
    typedef logic [SEG_W-1:0] seg_t;

    // Encoding table indexed by nibble value; entries listed from F down to 0
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'b1000111,
        7'b1001111,
        7'b0111101,
        7'b1001110,
        7'b0011111,
        7'b1110111,
        7'b1111011,
        7'b1111111,
        7'b1110000,
        7'b1011111,
        7'b1011011,
        7'b0110011,
        7'b1111001,
        7'b1101101,
        7'b0110000,
        7'b1111110
    };

endpackage

// File: rtl/seven_seg_mux_hex_to_seg.sv
// Combinational nibble-to-segment decoder producing the logical
// (active-high) segment pattern for one hex digit.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    // Straight table lookup; polarity is applied later at the output register
    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed hex display driver with a shadow register so that new
// values only appear on a frame boundary, optional leading-zero blanking and
// a global display enable.
// Optional feature: define SEVEN_SEG_DP_EN to add per-digit decimal points
// (input dp_in, output dp) that follow the same load/shadow/boundary rules.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [SEG_W-1:0]        seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending
`ifdef SEVEN_SEG_DP_EN
    ,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp
`endif
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic INVERT = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    boundary;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    zero_run;
    logic [3:0]              sel_nibble;
    logic                    sel_blank;
    logic [NUM_DIGITS-1:0]   an_logic;
    logic [NUM_DIGITS-1:0]   an_gated;
    seg_t                    dec_seg;
    seg_t                    seg_logic;

    assign tick     = (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // Refresh prescaler: counts 0..REFRESH_DIV-1, a wrap is one digit tick
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Digit index advances once per tick and wraps at the last digit
    always_ff @(posedge clk) begin
        if (!rst_n)
            idx <= '0;
        else if (tick)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // Shadow/display handoff: a load arriving on the boundary bypasses the shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_reg   <= '0;
            shadow_reg <= '0;
            pending    <= 1'b0;
        end else if (boundary) begin
            if (load)
                disp_reg <= value;
            else if (pending)
                disp_reg <= shadow_reg;
            pending <= 1'b0;
        end else if (load) begin
            shadow_reg <= value;
            pending    <= 1'b1;
        end
    end

    // Leading-zero mask: a digit blanks when it and everything above it is zero
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (disp_reg[4*i +: 4] == 4'h0);
            blank_mask[i] = blank_lz && zero_run && (i != 0);
        end
    end

    // Select the nibble, blank flag and anode for the digit currently scanned
    always_comb begin
        sel_nibble = 4'h0;
        sel_blank  = 1'b0;
        an_logic   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_nibble  = disp_reg[4*i +: 4];
                sel_blank   = blank_mask[i];
                an_logic[i] = 1'b1;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble (sel_nibble),
        .seg    (dec_seg)
    );

    // Apply blanking and the global enable in the logical (active-high) domain
    always_comb begin
        seg_logic = dec_seg;
        an_gated  = an_logic;
        if (!enable) begin
            seg_logic = '0;
            an_gated  = '0;
        end else if (sel_blank) begin
            seg_logic = '0;
        end
    end

    // Output register; polarity inversion happens here so the pins are glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= {SEG_W{INVERT}};
            an  <= {NUM_DIGITS{INVERT}};
        end else begin
            seg <= seg_logic ^ {SEG_W{INVERT}};
            an  <= an_gated ^ {NUM_DIGITS{INVERT}};
        end
    end

`ifdef SEVEN_SEG_DP_EN
    logic [NUM_DIGITS-1:0] dp_disp;
    logic [NUM_DIGITS-1:0] dp_shadow;
    logic                  dp_logic;

    // Decimal points ride along with the value through the same shadow handoff
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_disp   <= '0;
            dp_shadow <= '0;
        end else if (boundary) begin
            if (load)
                dp_disp <= dp_in;
            else if (pending)
                dp_disp <= dp_shadow;
        end else if (load) begin
            dp_shadow <= dp_in;
        end
    end

    // Pick the decimal point of the scanned digit; only enable can blank it
    always_comb begin
        dp_logic = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i))
                dp_logic = dp_disp[i];
        end
        dp_logic = dp_logic && enable;
    end

    // Decimal point output register, same timing and polarity as seg
    always_ff @(posedge clk) begin
        if (!rst_n)
            dp <= INVERT;
        else
            dp <= dp_logic ^ INVERT;
    end
`endif

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench for seven_seg_mux (NUM_DIGITS=4, REFRESH_DIV=4,
// ACTIVE_LOW=1). Stimulus pushes the expected registered outputs for each
// clock; an independent monitor pops and compares on the falling edge.
module tb_seven_seg_mux;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic        enable   = 1'b0;
    logic [15:0] value    = '0;
    logic [3:0]  dp_in    = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;
`ifdef SEVEN_SEG_DP_EN
    logic        dp;
`endif

    seven_seg_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .enable   (enable),
        .seg      (seg),
        .an       (an),
        .pending  (pending)
`ifdef SEVEN_SEG_DP_EN
        ,
        .dp_in    (dp_in),
        .dp       (dp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       pend;
        logic       dp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    string cur_tag = "reset";

    // Active-high segment patterns for hex digits 0..F
    logic [6:0] seg_hi [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Transaction-level view of the display: k counts clocks since reset release
    int          k = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_shadow = '0;
    logic        m_pend = 1'b0;
    logic [3:0]  m_dp_disp = '0;
    logic [3:0]  m_dp_shadow = '0;

    task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] v,
                                 input logic en, input logic blz, input logic [3:0] dpi);
        exp_t        e;
        int          digit;
        logic [15:0] shown;
        logic [3:0]  shown_dp;
        logic [3:0]  nib;
        logic        blanked;
        rst_n    = r;
        load     = ld;
        value    = v;
        enable   = en;
        blank_lz = blz;
        dp_in    = dpi;
        if (!r) begin
            k           = 0;
            m_disp      = '0;
            m_shadow    = '0;
            m_pend      = 1'b0;
            m_dp_disp   = '0;
            m_dp_shadow = '0;
            e.an   = 4'b1111;
            e.seg  = 7'b1111111;
            e.pend = 1'b0;
            e.dp   = 1'b1;
        end else begin
            shown    = m_disp;
            shown_dp = m_dp_disp;
            k++;
            if ((k % 16) == 0) begin
                if (ld) begin
                    m_disp    = v;
                    m_dp_disp = dpi;
                end else if (m_pend) begin
                    m_disp    = m_shadow;
                    m_dp_disp = m_dp_shadow;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                m_shadow    = v;
                m_dp_shadow = dpi;
                m_pend      = 1'b1;
            end
            digit   = ((k - 1) / 4) % 4;
            nib     = shown[4*digit +: 4];
            blanked = blz && (digit != 0) && ((shown >> (4*digit)) == 16'h0);
            if (!en) begin
                e.an  = 4'b1111;
                e.seg = 7'b1111111;
                e.dp  = 1'b1;
            end else begin
                e.an  = ~(4'b0001 << digit);
                e.seg = blanked ? 7'b1111111 : ~seg_hi[nib];
                e.dp  = ~shown_dp[digit];
            end
            e.pend = m_pend;
        end
        e.tag = cur_tag;
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic en, input logic blz);
        repeat (n) applyStimulus(1'b1, 1'b0, 16'h0000, en, blz, 4'h0);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (an !== e.an) begin
            errors++;
            $display("[TB] FAIL %s an got %b want %b", e.tag, an, e.an);
        end
        checks++;
        if (seg !== e.seg) begin
            errors++;
            $display("[TB] FAIL %s seg got %b want %b", e.tag, seg, e.seg);
        end
        checks++;
        if (pending !== e.pend) begin
            errors++;
            $display("[TB] FAIL %s pending got %b want %b", e.tag, pending, e.pend);
        end
`ifdef SEVEN_SEG_DP_EN
        checks++;
        if (dp !== e.dp) begin
            errors++;
            $display("[TB] FAIL %s dp got %b want %b", e.tag, dp, e.dp);
        end
`endif
    endtask

    // Monitor: compare registered outputs against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput(mon_e);
        end
    end

    initial begin
        cur_tag = "reset";
        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);

        cur_tag = "scan_zero";
        idle(20, 1'b1, 1'b0);

        cur_tag = "load_12af";
        applyStimulus(1'b1, 1'b1, 16'h12AF, 1'b1, 1'b0, 4'h0);
        cur_tag = "show_12af";
        idle(30, 1'b1, 1'b0);

        cur_tag = "blank_lz_0005";
        applyStimulus(1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 4'h0);
        idle(30, 1'b1, 1'b1);

        cur_tag = "last_load_wins";
        for (int i = 0; i < 16 && ((k + 1) % 16) != 5; i++) idle(1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 4'h0);
        idle(2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 16 && ((k + 1) % 16) != 0; i++) idle(1, 1'b1, 1'b0);
        cur_tag = "boundary_load";
        applyStimulus(1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 4'h0);
        idle(20, 1'b1, 1'b0);

        cur_tag = "enable_off";
        idle(10, 1'b0, 1'b0);
        cur_tag = "enable_on";
        idle(20, 1'b1, 1'b0);

        cur_tag = "reset_pending";
        for (int i = 0; i < 16 && ((k + 1) % 16) != 6; i++) idle(1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h4444, 1'b1, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
        cur_tag = "after_reset";
        idle(20, 1'b1, 1'b0);

        cur_tag = "dp_load";
        applyStimulus(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b0100);
        idle(36, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain queue got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits (range 2..8).
REQ-002 Parameter REFRESH_DIV, default 100000: clk cycles each digit is held (range 2..2^24).
REQ-003 Parameter ACTIVE_LOW, default 1: 1 drives seg and an active-low, 0 drives them active-high.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 load  input  1  one-cycle strobe that captures value into the shadow register.
REQ-007 value  input  4*NUM_DIGITS  hex nibbles; nibble 0 is the rightmost digit.
REQ-008 blank_lz  input  1  level; 1 enables leading-zero blanking.
REQ-009 enable  input  1  level; 0 blanks the whole display.
REQ-010 seg  output  7  segments a..g, bit 6 = a, bit 0 = g.
REQ-011 an  output  NUM_DIGITS  one-hot digit select.
REQ-012 pending  output  1  high while a loaded value waits for the frame boundary.

Function
REQ-013 The refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap; each wrap is a tick.
REQ-014 On each tick, digit index idx SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-015 A frame boundary SHALL be the tick on which idx wraps to 0.
REQ-016 On load with no boundary in the same cycle, the shadow register SHALL take value and pending SHALL go to 1.
REQ-017 At a boundary with pending=1, the display register SHALL take the shadow register and pending SHALL go to 0.
REQ-018 If load and a boundary occur in the same cycle, the display register SHALL take value directly and pending SHALL be 0.
REQ-019 Repeated loads before a boundary SHALL overwrite the shadow register; the last load wins.
REQ-020 seg and an SHALL be registered, and SHALL reflect idx and the display register one cycle after they change.
REQ-021 Nibble-to-segment encoding (active-high logical form) SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-022 With blank_lz=1, digits above the most-significant nonzero nibble SHALL show all segments off; digit 0 is never blanked.
REQ-023 With enable=0, all an and all seg SHALL be inactive; the counter, idx and the load path SHALL keep running.
REQ-024 ACTIVE_LOW=1 SHALL invert the logical seg and an values at the output register.

Reset
REQ-025 While rst_n=0 at a clk edge, the following SHALL be cleared to 0: counter, idx, display register, shadow register, pending.
REQ-026 While rst_n=0, seg and an SHALL be inactive (all 1 when ACTIVE_LOW=1).
REQ-027 Reset asserted mid-frame SHALL discard any pending value.
REQ-028 In the first cycle after rst_n rises, seg and an SHALL show digit 0 = "0".

Configuration
REQ-029 Macro SEVEN_SEG_DP_EN is the only compile-time option.
REQ-030 When SEVEN_SEG_DP_EN is defined, the block SHALL add input dp_in [NUM_DIGITS] and output dp [1].
REQ-031 dp_in SHALL be captured with the same load, shadow and boundary rules as value.
REQ-032 dp SHALL follow idx with the same timing and polarity as seg, and SHALL be blanked only by enable=0.
REQ-033 When SEVEN_SEG_DP_EN is undefined, neither port nor any related logic SHALL exist.

Structure
REQ-034 Package seven_seg_pkg SHALL hold the 16-entry segment encoding constant, the SEG_W=7 constant and the logical segment typedef.
REQ-035 The combinational nibble-to-segment decode SHALL be a sub-module named hex_to_seg, instantiated once on the selected nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-036 Reset release, enable=1, blank_lz=0 -> an rotates 1110, 1101, 1011, 0111 every 4 clks; seg=0000001 ("0") on every digit.
REQ-037 load value=16'h12AF mid-frame -> pending=1 until the next boundary; after the boundary the digits show F, A, 2, 1 (digit 0 first) and pending=0.
REQ-038 load value=16'h0005 with blank_lz=1 -> digit 0 seg=0100100; digits 1-3 seg=1111111 with their an still scanning.
REQ-039 Two loads (16'h1111, then 16'h2222) in one frame, then a load on the boundary cycle with 16'h3333 -> display=3333 immediately and pending=0.
REQ-040 enable=0 for 10 clks during scan -> an=1111 and seg=1111111; after enable returns, idx continues from where the counter has advanced.
REQ-041 rst_n low for 1 clk with pending=1 -> pending=0 and display=0000 afterwards; with SEVEN_SEG_DP_EN defined, dp_in=4'b0100 loaded -> dp=0 (lit) only while an=1011.
